// File: rtl/rr_channel_arbiter.sv
// rtl/rr_channel_arbiter.sv - round-robin channel arbiter with output register; ARB_STALL_CNT_EN adds stall_cnt
module rr_channel_arbiter #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 10,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    output logic [CHANNELS-1:0]       grant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W:0]     scan_idx;
    logic [WIDTH-1:0]   win_data;
    logic               load;

    // grant is suppressed while reset is held, even with requests present
    assign load = reset_n & (|req) & ((state == EMPTY) | out_ready);

    // Scan from the farthest offset down so the nearest requester after ptr wins;
    // the index wraps modulo CHANNELS so out-of-range selects are never formed.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (scan_idx >= (SEL_W + 1)'(CHANNELS)) begin
                scan_idx = scan_idx - (SEL_W + 1)'(CHANNELS);
            end
            if (req[scan_idx[SEL_W-1:0]]) begin
                winner = scan_idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        grant    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner == SEL_W'(i)) begin
                win_data = in_bus[i*WIDTH +: WIDTH];
                grant[i] = load;
            end
        end
    end

    assign ptr_nxt = (winner == SEL_W'(CHANNELS - 1)) ? '0 : winner + SEL_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (out_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            out_data <= '0;
            out_chan <= '0;
        end else if (load) begin
            ptr      <= ptr_nxt;
            out_data <= win_data;
            out_chan <= winner;
        end
    end

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// tb/tb_rr_channel_arbiter.sv - scoreboard bench for rr_channel_arbiter (4- and 10-channel instances)
module tb_rr_channel_arbiter;

    typedef struct packed {
        logic [3:0]  chan;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         reset_n;

    logic [3:0]   req4;
    logic [127:0] bus4;
    logic [3:0]   grant4;
    logic         out_valid4;
    logic         out_ready4;
    logic [31:0]  out_data4;
    logic [1:0]   out_chan4;

    logic [9:0]   req10;
    logic [319:0] bus10;
    logic [9:0]   grant10;
    logic         out_valid10;
    logic         out_ready10;
    logic [31:0]  out_data10;
    logic [3:0]   out_chan10;

`ifdef ARB_STALL_CNT_EN
    logic [15:0]  stall_cnt4;
    logic [15:0]  stall_cnt10;
`endif

    int tests = 0;
    int fails = 0;
    exp_t q4[$];
    exp_t q10[$];

    rr_channel_arbiter #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req4),
        .in_bus    (bus4),
        .grant     (grant4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_chan  (out_chan4)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt4)
`endif
    );

    rr_channel_arbiter #(.WIDTH(32), .CHANNELS(10)) u_dut10 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req10),
        .in_bus    (bus10),
        .grant     (grant10),
        .out_valid (out_valid10),
        .out_ready (out_ready10),
        .out_data  (out_data10),
        .out_chan  (out_chan10)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt10)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitors: every accepted word must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                chk("mon4_unexpected_word", {30'd0, out_chan4}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("mon4_chan", {30'd0, out_chan4}, {28'd0, e.chan});
                chk("mon4_data", out_data4, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid10 && out_ready10) begin
            if (q10.size() == 0) begin
                chk("mon10_unexpected_word", {28'd0, out_chan10}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q10.pop_front();
                chk("mon10_chan", {28'd0, out_chan10}, {28'd0, e.chan});
                chk("mon10_data", out_data10, e.data);
            end
        end
    end

    task automatic push4(input logic [3:0] c, input logic [31:0] d);
        exp_t e;
        e.chan = c;
        e.data = d;
        q4.push_back(e);
    endtask

    task automatic push10(input logic [3:0] c, input logic [31:0] d);
        exp_t e;
        e.chan = c;
        e.data = d;
        q10.push_back(e);
    endtask

    // one clock of 4-channel stimulus; grant is checked mid-cycle, returns at posedge+1
    task automatic step4(input logic [3:0] r, input logic rdy, input logic [3:0] exp_grant);
        req4       = r;
        out_ready4 = rdy;
        @(negedge clk);
        chk("grant4", {28'd0, grant4}, {28'd0, exp_grant});
        @(posedge clk);
        #1;
    endtask

    task automatic step10(input logic [9:0] r, input logic [9:0] exp_grant);
        req10 = r;
        @(negedge clk);
        chk("grant10", {22'd0, grant10}, {22'd0, exp_grant});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        req4        = 4'hF;
        out_ready4  = 1'b0;
        req10       = 10'h3FF;
        out_ready10 = 1'b1;
        for (int i = 0; i < 4; i++) bus4[i*32 +: 32] = 32'hA0 + i;
        for (int i = 0; i < 10; i++) bus10[i*32 +: 32] = 32'hB0 + i;

        // reset state with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant4", {28'd0, grant4}, 32'd0);
        chk("rst_grant10", {22'd0, grant10}, 32'd0);
        chk("rst_valid4", {31'd0, out_valid4}, 32'd0);
        chk("rst_data4", out_data4, 32'd0);
        chk("rst_chan4", {30'd0, out_chan4}, 32'd0);
`ifdef ARB_STALL_CNT_EN
        chk("rst_stall4", {16'd0, stall_cnt4}, 32'd0);
`endif
        @(posedge clk);
        #1;
        req10   = 10'h000;
        reset_n = 1'b1;

        // round-robin with sustained throughput
        push4(0, 32'hA0); step4(4'hF, 1'b1, 4'b0001);
        push4(1, 32'hA1); step4(4'hF, 1'b1, 4'b0010);
        push4(2, 32'hA2); step4(4'hF, 1'b1, 4'b0100);
        push4(3, 32'hA3); step4(4'hF, 1'b1, 4'b1000);
        push4(0, 32'hA0); step4(4'hF, 1'b1, 4'b0001);
        step4(4'h0, 1'b1, 4'b0000);
        chk("rr_drained_valid", {31'd0, out_valid4}, 32'd0);

        // wrap and skip: ptr=3 after channel 2, then req 0101
        push4(2, 32'hA2); step4(4'b0100, 1'b1, 4'b0100);
        push4(0, 32'hA0); step4(4'b0101, 1'b1, 4'b0001);
        push4(2, 32'hA2); step4(4'b0101, 1'b1, 4'b0100);
        step4(4'h0, 1'b1, 4'b0000);

        // backpressure: ptr=3, capture 1234 from channel 3 then stall 5 cycles
        bus4[3*32 +: 32] = 32'h1234;
        push4(3, 32'h1234); step4(4'hF, 1'b0, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            step4(4'hF, 1'b0, 4'b0000);
            chk("bp_hold_data", out_data4, 32'h1234);
            chk("bp_hold_valid", {31'd0, out_valid4}, 32'd1);
        end
`ifdef ARB_STALL_CNT_EN
        chk("bp_stall_cnt", {16'd0, stall_cnt4}, 32'd5);
`endif
        push4(0, 32'hA0); step4(4'hF, 1'b1, 4'b0001);
        chk("bp_next_chan", {30'd0, out_chan4}, 32'd0);
        step4(4'h0, 1'b1, 4'b0000);

        // drain: single pulse on channel 1 (ptr=1)
        push4(1, 32'hA1); step4(4'b0010, 1'b1, 4'b0010);
        chk("drain_valid_hi", {31'd0, out_valid4}, 32'd1);
        chk("drain_chan", {30'd0, out_chan4}, 32'd1);
        step4(4'h0, 1'b1, 4'b0000);
        chk("drain_valid_lo", {31'd0, out_valid4}, 32'd0);
        chk("drain_chan_kept", {30'd0, out_chan4}, 32'd1);

        // mid-operation reset while FULL; ptr=2 so channel 0 wins via wrap
        step4(4'b0001, 1'b0, 4'b0001);
        chk("mrst_full", {31'd0, out_valid4}, 32'd1);
        req4 = 4'h0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid_async", {31'd0, out_valid4}, 32'd0);
        chk("mrst_data", out_data4, 32'd0);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        out_ready4 = 1'b1;

        // 10-channel wrap at ptr=9
        push10(8, 32'hB8); step10(10'h100, 10'h100);
        push10(9, 32'hB9); step10(10'h200, 10'h200);
        push10(0, 32'hB0); step10(10'h201, 10'h001);
        step10(10'h000, 10'h000);
        step10(10'h000, 10'h000);
        chk("w10_idle_valid", {31'd0, out_valid10}, 32'd0);

        chk("q4_empty", q4.size(), 32'd0);
        chk("q10_empty", q10.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_channel_arbiter.md
Name: rr_channel_arbiter

Overview:
- Round-robin arbiter and output register for the ALU channel multiplexer.
- Accepts up to CHANNELS WIDTH-bit request words on a packed bus, using the same packing as the mux: channel i occupies in_bus[i*WIDTH +: WIDTH].
- Picks one requester fairly and produces the mux select index. Holds the selected word in an output register with a valid/ready handshake.
- Sits directly upstream of the channel mux; out_chan drives its sel input.

Parameters:
- WIDTH, 32, data width per channel
- CHANNELS, 10, number of requesters; must be >= 2
- SEL_W, derived localparam = ceil(log2(CHANNELS)); width of the index outputs (4 for the default)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  CHANNELS  per-channel request; bit i qualifies in_bus slice i
- in_bus  input  CHANNELS*WIDTH  packed channel data
- grant  output  CHANNELS  one-hot, combinational; channel whose word is captured at the next clk edge
- out_valid  output  1  out_data/out_chan hold a captured word
- out_ready  input  1  downstream accepts the word
- out_data  output  WIDTH  captured word
- out_chan  output  SEL_W  index of the captured channel; feeds mux sel
- stall_cnt  output  16  present only with ARB_STALL_CNT_EN

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, out_data=0, out_chan=0, ptr=0, stall_cnt=0.
  - grant=0 while in reset.
  - Reset mid-transfer discards the held word; nothing is replayed.
- Internal state:
  - ptr[SEL_W-1:0] = highest-priority channel.
  - Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- load = (|req) & (~out_valid | out_ready).
- Winner selection:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1.
  - The scan wraps modulo CHANNELS, not modulo 2^SEL_W.
- grant[winner]=load; all other grant bits are 0. A requester treats grant as consumption of its word at that edge.
- On a clk edge with load=1:
  - out_data <= in_bus slice of winner; out_chan <= winner; out_valid <= 1.
  - ptr <= winner+1, wrapping to 0 when winner = CHANNELS-1.
- On a clk edge with out_valid & out_ready & ~|req: out_valid <= 0. out_data and out_chan keep their last values.
- FULL & ~out_ready: out_data and out_chan are frozen, grant=0, and req is ignored.
- Simultaneous accept + new request: the register reloads in the same cycle, giving one word per cycle of sustained throughput with no bubble.
- Latency: req asserted in cycle N with the register EMPTY (or draining) -> out_valid=1 in cycle N+1.
- ptr changes only on load.
- out_chan index values >= CHANNELS are never produced.
- Once asserted, out_valid stays high until accepted; out_data is stable while out_valid & ~out_ready.
- A single requester with req held high is granted every cycle the register can accept.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- Defined:
  - Adds the stall_cnt port and a 16-bit counter.
  - Counter increments each cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF.
  - Cleared only by reset.
- Undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Test Plan (CHANNELS=4, WIDTH=32 unless noted):
- Reset: hold reset_n=0 with req=4'hF -> grant=0, out_valid=0, out_data=0, out_chan=0. Release reset -> first grant goes to channel 0.
- Round-robin: req=4'hF held, out_ready=1, slice i=32'hA0+i -> out_chan sequence 0,1,2,3,0; out_data sequence 32'hA0..A3, A0. out_valid stays high from cycle 2 with no bubble.
- Wrap/skip: ptr=3 after granting channel 2, req=4'b0101 -> grant=4'b0001, out_chan=0, then ptr=1. The next grant with the same req goes to channel 2.
- Backpressure: out_valid=1 holding 32'h1234, out_ready=0 for 5 cycles, req=4'hF -> grant=0 and out_data=32'h1234 stable. With ARB_STALL_CNT_EN, stall_cnt=5. Raise out_ready -> next channel is captured at the following edge.
- Drain: single req pulse on channel 1, out_ready=1 -> out_valid high exactly one cycle with out_chan=1, then 0.
- Mid-operation reset and odd size:
  - Assert reset_n=0 while FULL -> out_valid drops immediately, without a clock edge.
  - With CHANNELS=10, req=10'h200 with ptr=9 -> out_chan=9, then ptr wraps to 0.
